// File: rtl/sram_pkg.sv
// ============================================================================
// Module : sram_pkg
// Brief  : Shared constants, FSM state type and lane helpers for the SRAM responder.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package sram_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int LANES  = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } sram_state_t;

    function automatic logic [DATA_W-1:0] lane_mask(input logic [LANES-1:0] be);
        logic [DATA_W-1:0] m;
        for (int i = 0; i < LANES; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    function automatic logic [LANES-1:0] lane_parity(input logic [DATA_W-1:0] d);
        logic [LANES-1:0] p;
        for (int i = 0; i < LANES; i++) begin
            p[i] = ^d[8*i +: 8];
        end
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sram_responder_if.sv
// ============================================================================
// Module : sram_responder_if
// Brief  : MMU <-> SRAM responder request/response bundle (parity signals with SRAM_PARITY_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface sram_responder_if;
    import sram_pkg::*;

    logic [ADDR_W-1:0] SRAM_addr_sel;
    logic [LANES-1:0]  SRAM_byte_sel;
    logic              read_pulse;
    logic              write_pulse;
    logic [DATA_W-1:0] SRAM_dat_in;
    logic [DATA_W-1:0] SRAM_dat_out;
    logic              SRAM_ack;
    logic              SRAM_busy;
    logic              SRAM_err;
`ifdef SRAM_PARITY_EN
    logic              parity_inject;
    logic              SRAM_perr;
`endif

    modport slave (
        input  SRAM_addr_sel, SRAM_byte_sel, read_pulse, write_pulse, SRAM_dat_in,
`ifdef SRAM_PARITY_EN
        input  parity_inject,
        output SRAM_perr,
`endif
        output SRAM_dat_out, SRAM_ack, SRAM_busy, SRAM_err
    );

    modport master (
        output SRAM_addr_sel, SRAM_byte_sel, read_pulse, write_pulse, SRAM_dat_in,
`ifdef SRAM_PARITY_EN
        output parity_inject,
        input  SRAM_perr,
`endif
        input  SRAM_dat_out, SRAM_ack, SRAM_busy, SRAM_err
    );

endinterface

`default_nettype wire

// File: rtl/sram_array.sv
// ============================================================================
// Module : sram_array
// Brief  : 128x32 storage, per-lane write enables, registered read (parity columns
//          added when SRAM_PARITY_EN is defined).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_array
    import sram_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [LANES-1:0]  i_be,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
`ifdef SRAM_PARITY_EN
    ,
    input  wire logic [LANES-1:0]  i_wpar,
    output logic      [LANES-1:0]  o_rpar
`endif
);

    // One memory per byte lane so each lane has a single write process.
    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            logic [7:0] r_mem [DEPTH];
            logic [7:0] r_rd;

            always_ff @(posedge clk) begin
                if (i_we && i_be[i]) begin
                    r_mem[i_waddr] <= i_wdata[8*i +: 8];
                end
                r_rd <= r_mem[i_raddr];
            end

            assign o_rdata[8*i +: 8] = r_rd;

`ifdef SRAM_PARITY_EN
            logic r_pmem [DEPTH];
            logic r_prd;

            always_ff @(posedge clk) begin
                if (i_we && i_be[i]) begin
                    r_pmem[i_waddr] <= i_wpar[i];
                end
                r_prd <= r_pmem[i_raddr];
            end

            assign o_rpar[i] = r_prd;
`endif
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/sram_responder.sv
// ============================================================================
// Module : sram_responder
// Brief  : Edge-triggered SRAM request FSM with fixed read/write latency and ack strobe.
//          Optional per-lane parity via SRAM_PARITY_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sram_responder
    import sram_pkg::*;
#(
    parameter int RD_LAT = 2,
    parameter int WR_LAT = 1
) (
    input  wire logic        soc_clk,
    input  wire logic        soc_rst,
    sram_responder_if.slave  bus
);

    localparam logic [2:0] C_RD_CNT = 3'(RD_LAT - 1);
    localparam logic [2:0] C_WR_CNT = 3'(WR_LAT - 1);

    sram_state_t       r_state;
    logic [2:0]        r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [LANES-1:0]  r_be;
    logic [DATA_W-1:0] r_data;
    logic              r_rd_prev;
    logic              r_wr_prev;
    logic              r_wr_go;
    logic              r_ack;
    logic              r_busy;
    logic              r_err;
    logic [DATA_W-1:0] r_dat_out;

    logic              w_rd_rise;
    logic              w_wr_rise;
    logic [ADDR_W-1:0] w_raddr;
    logic [DATA_W-1:0] w_rdata;

    assign w_rd_rise = bus.read_pulse  & ~r_rd_prev;
    assign w_wr_rise = bus.write_pulse & ~r_wr_prev;

    // Reading the live address while idle makes the word ready for RD_LAT = 1.
    assign w_raddr = (r_state == IDLE) ? bus.SRAM_addr_sel : r_addr;

`ifdef SRAM_PARITY_EN
    logic              r_inj;
    logic              r_perr;
    logic [LANES-1:0]  w_wpar;
    logic [LANES-1:0]  w_rpar;
    logic              w_perr;

    assign w_wpar = lane_parity(r_data) ^ {LANES{r_inj}};
    assign w_perr = |((lane_parity(w_rdata) ^ w_rpar) & r_be);
    assign bus.SRAM_perr = r_perr;
`endif

    sram_array u_array (
        .clk     (soc_clk),
        .i_we    (r_wr_go),
        .i_waddr (r_addr),
        .i_be    (r_be),
        .i_wdata (r_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
`ifdef SRAM_PARITY_EN
        ,
        .i_wpar  (w_wpar),
        .o_rpar  (w_rpar)
`endif
    );

    always_ff @(posedge soc_clk) begin
        if (soc_rst) begin
            r_state   <= IDLE;
            r_cnt     <= 3'd0;
            r_addr    <= '0;
            r_be      <= '0;
            r_data    <= '0;
            r_rd_prev <= 1'b0;
            r_wr_prev <= 1'b0;
            r_wr_go   <= 1'b0;
            r_ack     <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
            r_dat_out <= '0;
`ifdef SRAM_PARITY_EN
            r_inj     <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_rd_prev <= bus.read_pulse;
            r_wr_prev <= bus.write_pulse;
            r_ack     <= 1'b0;
            r_err     <= 1'b0;
            r_wr_go   <= 1'b0;
`ifdef SRAM_PARITY_EN
            r_perr    <= 1'b0;
`endif
            case (r_state)
                IDLE: begin
                    if (w_rd_rise && w_wr_rise) begin
                        r_err <= 1'b1;
                    end else if (w_rd_rise || w_wr_rise) begin
                        r_state <= w_rd_rise ? RD_WAIT : WR_WAIT;
                        r_cnt   <= w_rd_rise ? C_RD_CNT : C_WR_CNT;
                        r_addr  <= bus.SRAM_addr_sel;
                        r_be    <= bus.SRAM_byte_sel;
                        r_data  <= bus.SRAM_dat_in;
                        r_busy  <= 1'b1;
                        r_wr_go <= w_wr_rise;
`ifdef SRAM_PARITY_EN
                        r_inj   <= bus.parity_inject;
`endif
                    end
                end
                RD_WAIT, WR_WAIT: begin
                    // Edges seen here are consumed by the prev registers and never replayed.
                    if (r_ack) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == 3'd0) begin
                        r_ack <= 1'b1;
                        if (r_state == RD_WAIT) begin
                            r_dat_out <= w_rdata & lane_mask(r_be);
`ifdef SRAM_PARITY_EN
                            r_perr    <= w_perr;
`endif
                        end
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SRAM_dat_out = r_dat_out;
    assign bus.SRAM_ack     = r_ack;
    assign bus.SRAM_busy    = r_busy;
    assign bus.SRAM_err     = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sram_responder.sv
// ============================================================================
// Module : tb_sram_responder
// Brief  : Scoreboard bench for sram_responder (parity cases with SRAM_PARITY_EN).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_sram_responder;

    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;

    typedef struct {
        logic        is_rd;
        logic [31:0] data;
        logic        perr;
        int          cyc;
    } exp_t;

    logic clk;
    logic soc_rst;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    exp_t q[$];

    logic [31:0] model_mem [128];
    logic [3:0]  model_par [128];

    sram_responder_if bus ();

    sram_responder #(
        .RD_LAT (RD_LAT),
        .WR_LAT (WR_LAT)
    ) dut (
        .soc_clk (clk),
        .soc_rst (soc_rst),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask_of(input logic [3:0] be);
        logic [31:0] m = 32'h0;
        for (int i = 0; i < 4; i++) if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [3:0] par_of(input logic [31:0] d);
        logic [3:0] p;
        for (int i = 0; i < 4; i++) p[i] = ^d[8*i +: 8];
        return p;
    endfunction

    // Scoreboard: every ack consumes one expected completion.
    always @(negedge clk) begin
        if (!soc_rst && bus.SRAM_ack) begin
            if (q.size() == 0) begin
                check("unexpected_ack", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("ack_latency", cyc, e.cyc);
                if (e.is_rd) check("rd_data", bus.SRAM_dat_out, e.data);
`ifdef SRAM_PARITY_EN
                check("perr", {31'd0, bus.SRAM_perr}, {31'd0, e.perr});
`endif
            end
        end
    end

    task automatic wait_done();
        int k = 0;
        while (q.size() != 0 && k < 30) begin
            @(posedge clk);
            k++;
        end
        if (q.size() != 0) begin
            check("ack_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [3:0] be,
                            input logic [31:0] d, input logic inj);
        exp_t e;
        @(posedge clk); #2;
        bus.SRAM_addr_sel = a;
        bus.SRAM_byte_sel = be;
        bus.SRAM_dat_in   = d;
        bus.write_pulse   = 1'b1;
`ifdef SRAM_PARITY_EN
        bus.parity_inject = inj;
`endif
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                model_mem[a][8*i +: 8] = d[8*i +: 8];
                model_par[a][i]        = (^d[8*i +: 8]) ^ inj;
            end
        end
        e.is_rd = 1'b0; e.data = 32'h0; e.perr = 1'b0; e.cyc = cyc + 1 + WR_LAT;
        q.push_back(e);
        @(posedge clk); #2;
        bus.write_pulse = 1'b0;
`ifdef SRAM_PARITY_EN
        bus.parity_inject = 1'b0;
`endif
        wait_done();
    endtask

    task automatic push_read(input logic [6:0] a, input logic [3:0] be);
        exp_t e;
        e.is_rd = 1'b1;
        e.data  = model_mem[a] & mask_of(be);
        e.perr  = |((par_of(model_mem[a]) ^ model_par[a]) & be);
        e.cyc   = cyc + 1 + RD_LAT;
        q.push_back(e);
    endtask

    task automatic do_read(input logic [6:0] a, input logic [3:0] be);
        @(posedge clk); #2;
        bus.SRAM_addr_sel = a;
        bus.SRAM_byte_sel = be;
        bus.read_pulse    = 1'b1;
        push_read(a, be);
        @(posedge clk); #2;
        bus.read_pulse = 1'b0;
        wait_done();
    endtask

    initial begin
        soc_rst           = 1'b1;
        bus.read_pulse    = 1'b0;
        bus.write_pulse   = 1'b0;
        bus.SRAM_addr_sel = 7'd0;
        bus.SRAM_byte_sel = 4'h0;
        bus.SRAM_dat_in   = 32'h0;
`ifdef SRAM_PARITY_EN
        bus.parity_inject = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #2;
        check("rst_dat_out", bus.SRAM_dat_out, 32'h0);
        check("rst_ack",  {31'd0, bus.SRAM_ack},  32'd0);
        check("rst_busy", {31'd0, bus.SRAM_busy}, 32'd0);
        check("rst_err",  {31'd0, bus.SRAM_err},  32'd0);
        soc_rst = 1'b0;

        // Full word, then partial lane writes and masked reads.
        do_write(7'd5, 4'b1111, 32'hDEADBEEF, 1'b0);
        do_read(7'd5, 4'b1111);
        do_write(7'd5, 4'b0010, 32'h0000AA00, 1'b0);
        do_read(7'd5, 4'b1111);
        do_read(7'd5, 4'b0001);
        do_write(7'd5, 4'b0000, 32'hFFFFFFFF, 1'b0);
        do_read(7'd5, 4'b1111);

        // Simultaneous read/write rising edges are rejected.
        @(posedge clk); #2;
        bus.SRAM_dat_in = 32'h11111111;
        bus.read_pulse  = 1'b1;
        bus.write_pulse = 1'b1;
        @(posedge clk); #2;
        check("both_err",  {31'd0, bus.SRAM_err},  32'd1);
        check("both_busy", {31'd0, bus.SRAM_busy}, 32'd0);
        bus.read_pulse  = 1'b0;
        bus.write_pulse = 1'b0;
        @(posedge clk); #2;
        check("both_err_clr", {31'd0, bus.SRAM_err}, 32'd0);
        do_read(7'd5, 4'b1111);

        // A second read edge while busy is ignored.
        @(posedge clk); #2;
        bus.read_pulse = 1'b1;
        push_read(7'd5, 4'b1111);
        @(posedge clk); #2;
        bus.read_pulse = 1'b0;
        @(posedge clk); #2;
        check("busy_mid_rd", {31'd0, bus.SRAM_busy}, 32'd1);
        bus.read_pulse = 1'b1;
        @(posedge clk); #2;
        check("no_err_busy", {31'd0, bus.SRAM_err}, 32'd0);
        bus.read_pulse = 1'b0;
        wait_done();
        repeat (6) @(posedge clk);

        // Held read pulse counts once.
        @(posedge clk); #2;
        bus.read_pulse = 1'b1;
        push_read(7'd5, 4'b1111);
        repeat (10) @(posedge clk);
        #2;
        bus.read_pulse = 1'b0;
        wait_done();
        repeat (4) @(posedge clk);

        // Reset in RD_WAIT aborts without ack.
        @(posedge clk); #2;
        bus.read_pulse = 1'b1;
        @(posedge clk); #2;
        check("busy_before_rst", {31'd0, bus.SRAM_busy}, 32'd1);
        soc_rst        = 1'b1;
        bus.read_pulse = 1'b0;
        @(posedge clk); #2;
        check("busy_after_rst", {31'd0, bus.SRAM_busy}, 32'd0);
        check("ack_after_rst",  {31'd0, bus.SRAM_ack},  32'd0);
        soc_rst = 1'b0;
        repeat (5) @(posedge clk);
        do_read(7'd5, 4'b1111);

        // Address extremes do not alias.
        do_write(7'd127, 4'b1111, 32'h12345678, 1'b0);
        do_write(7'd0,   4'b1111, 32'h00000000, 1'b0);
        do_read(7'd127, 4'b1111);
        do_read(7'd0,   4'b1111);

`ifdef SRAM_PARITY_EN
        do_write(7'd3, 4'b1111, 32'hA5A50F01, 1'b0);
        do_write(7'd3, 4'b0001, 32'h00000007, 1'b1);
        do_read(7'd3, 4'b0001);
        do_read(7'd3, 4'b1110);
`endif

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
